// File: rtl/gcm_lane_dispatcher.sv
// Packet front end for parallel AES-GCM engine lanes: phase/size tracking, skewed issue,
// deskewed realignment of ciphertext with bypass text. Optional counters: GCM_LANE_STATS_EN.
module gcm_lane_dispatcher #(
    parameter int LANES     = 2,
    parameter int BYPASS_W  = 289,
    parameter int ENG_LAT   = 30,
    parameter int LANE_SKEW = 1,
    parameter int LEN_LSB   = 33,
    parameter int HDR_BYTES = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic                 i_sop,
    input  logic                 i_eop,
    input  logic [128*LANES-1:0] i_data,
    input  logic [BYPASS_W-1:0]  i_bypass,
    output logic [LANES-1:0]     o_eng_new,
    output logic [LANES-1:0]     o_eng_last,
    output logic [128*LANES-1:0] o_eng_pt,
    output logic [127:0]         o_pt_size,
    input  logic [LANES-1:0]     i_eng_ready,
    input  logic [128*LANES-1:0] i_eng_ct,
    output logic                 o_valid,
    output logic                 o_sop,
    output logic                 o_eop,
    output logic [2:0]           o_phase,
    output logic [128*LANES-1:0] o_cipher,
    output logic [BYPASS_W-1:0]  o_bypass,
`ifdef GCM_LANE_STATS_EN
    output logic [31:0]          o_pkt_cnt,
    output logic [15:0]          o_err_cnt,
`endif
    output logic                 o_err
);

    localparam int DW  = 128 * LANES;
    localparam int DLY = ENG_LAT + (LANES - 1) * LANE_SKEW + 1;

    typedef enum logic [2:0] {
        ST_FIRST  = 3'b001,
        ST_SECOND = 3'b010,
        ST_INNER  = 3'b100
    } state_e;

    typedef struct packed {
        logic                v;
        logic                sop;
        logic                eop;
        logic [2:0]          phase;
        logic [BYPASS_W-1:0] byp;
    } beat_t;

    state_e              state_q, state_d;
    logic                accept;
    logic                in_err;
    logic [2:0]          beat_phase;
    logic [15:0]         len;
    logic [15:0]         len_net;
    logic                len_err;
    logic [127:0]        size_q, size_d;
    beat_t               pipe_q [DLY];
    beat_t               pipe_d [DLY];
    beat_t               tail;
    logic [LANES-1:0]    rdy_err;
    logic [DW-1:0]       ct_al;
    logic                err_evt;
    logic                o_valid_q, o_valid_d;
    logic                o_sop_q, o_sop_d;
    logic                o_eop_q, o_eop_d;
    logic [2:0]          o_phase_q, o_phase_d;
    logic [DW-1:0]       o_cipher_q, o_cipher_d;
    logic [BYPASS_W-1:0] o_bypass_q, o_bypass_d;
    logic                o_err_q, o_err_d;

    // A sop always opens a new packet, even if it truncates the current one.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        in_err     = 1'b0;
        beat_phase = state_q;
        if (i_valid) begin
            if (i_sop) begin
                accept     = 1'b1;
                beat_phase = ST_FIRST;
                in_err     = (state_q != ST_FIRST);
                state_d    = i_eop ? ST_FIRST : ST_SECOND;
            end else if (state_q == ST_FIRST) begin
                in_err = 1'b1;
            end else begin
                accept  = 1'b1;
                state_d = i_eop ? ST_FIRST : ST_INNER;
            end
        end
    end

    always_comb begin
        len     = i_bypass[LEN_LSB +: 16];
        len_net = len - 16'(HDR_BYTES);
        size_d  = size_q;
        len_err = 1'b0;
        if (accept && i_sop) begin
            if (len < 16'(HDR_BYTES)) begin
                size_d  = '0;
                len_err = 1'b1;
            end else begin
                size_d = {{109{1'b0}}, len_net, 3'b000};
            end
        end
    end

    // Side-band delay line; stage k holds a beat during cycle t+1+k.
    always_comb begin
        pipe_d[0].v     = accept;
        pipe_d[0].sop   = i_sop;
        pipe_d[0].eop   = i_eop;
        pipe_d[0].phase = beat_phase;
        pipe_d[0].byp   = i_bypass;
        for (int k = 1; k < DLY; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DLY; k++) begin
            if (reset) pipe_q[k].v <= 1'b0;
            else       pipe_q[k]   <= pipe_d[k];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int IS = l * LANE_SKEW;
        localparam int DS = (LANES - 1 - l) * LANE_SKEW;

        logic [127:0] iss_q [IS+1];
        logic [127:0] iss_d [IS+1];

        always_comb begin
            iss_d[0] = i_data[128*l +: 128];
            for (int k = 1; k <= IS; k++) begin
                iss_d[k] = iss_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            iss_q <= iss_d;
        end

        assign o_eng_new[l]          = pipe_q[IS].v;
        assign o_eng_last[l]         = pipe_q[IS].v & pipe_q[IS].eop;
        assign o_eng_pt[128*l +: 128] = pipe_q[IS].v ? iss_q[IS] : '0;
        assign rdy_err[l]            = i_eng_ready[l] != pipe_q[IS+ENG_LAT].v;

        if (DS == 0) begin : g_direct
            assign ct_al[128*l +: 128] = i_eng_ct[128*l +: 128];
        end else begin : g_deskew
            logic [127:0] dsk_q [DS];
            logic [127:0] dsk_d [DS];

            always_comb begin
                dsk_d[0] = i_eng_ct[128*l +: 128];
                for (int k = 1; k < DS; k++) begin
                    dsk_d[k] = dsk_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                dsk_q <= dsk_d;
            end

            assign ct_al[128*l +: 128] = dsk_q[DS-1];
        end
    end

    always_comb begin
        tail       = pipe_q[DLY-1];
        o_valid_d  = tail.v;
        o_sop_d    = tail.v & tail.sop;
        o_eop_d    = tail.v & tail.eop;
        o_phase_d  = tail.v ? tail.phase : 3'b000;
        o_cipher_d = tail.v ? ct_al : o_cipher_q;
        o_bypass_d = tail.v ? tail.byp : o_bypass_q;
        err_evt    = in_err | len_err | (|rdy_err);
        o_err_d    = o_err_q | err_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FIRST;
            size_q     <= '0;
            o_valid_q  <= 1'b0;
            o_sop_q    <= 1'b0;
            o_eop_q    <= 1'b0;
            o_phase_q  <= '0;
            o_cipher_q <= '0;
            o_bypass_q <= '0;
            o_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            o_valid_q  <= o_valid_d;
            o_sop_q    <= o_sop_d;
            o_eop_q    <= o_eop_d;
            o_phase_q  <= o_phase_d;
            o_cipher_q <= o_cipher_d;
            o_bypass_q <= o_bypass_d;
            o_err_q    <= o_err_d;
        end
    end

    assign o_pt_size = size_q;
    assign o_valid   = o_valid_q;
    assign o_sop     = o_sop_q;
    assign o_eop     = o_eop_q;
    assign o_phase   = o_phase_q;
    assign o_cipher  = o_cipher_q;
    assign o_bypass  = o_bypass_q;
    assign o_err     = o_err_q;

`ifdef GCM_LANE_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q + {31'd0, tail.v & tail.eop};
        err_cnt_d = err_cnt_q;
        if (err_evt && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_pkt_cnt = pkt_cnt_q;
    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_gcm_lane_dispatcher.sv
// Directed bench for gcm_lane_dispatcher with a fixed-latency XOR engine model.
// Stats ports are checked when GCM_LANE_STATS_EN is defined.
module tb_gcm_lane_dispatcher;

    localparam int LANES     = 2;
    localparam int BYPASS_W  = 289;
    localparam int ENG_LAT   = 30;
    localparam int LANE_SKEW = 1;
    localparam int LEN_LSB   = 33;
    localparam int HDR_BYTES = 14;
    localparam int OUT_LAT   = 33;
    localparam int DW        = 128 * LANES;

    logic                clk = 1'b0;
    logic                reset;
    logic                i_valid, i_sop, i_eop;
    logic [DW-1:0]       i_data;
    logic [BYPASS_W-1:0] i_bypass;
    logic [LANES-1:0]    o_eng_new, o_eng_last;
    logic [DW-1:0]       o_eng_pt;
    logic [127:0]        o_pt_size;
    logic [LANES-1:0]    i_eng_ready;
    logic [DW-1:0]       i_eng_ct;
    logic                o_valid, o_sop, o_eop;
    logic [2:0]          o_phase;
    logic [DW-1:0]       o_cipher;
    logic [BYPASS_W-1:0] o_bypass;
    logic                o_err;
`ifdef GCM_LANE_STATS_EN
    logic [31:0]         o_pkt_cnt;
    logic [15:0]         o_err_cnt;
`endif

    gcm_lane_dispatcher #(
        .LANES(LANES), .BYPASS_W(BYPASS_W), .ENG_LAT(ENG_LAT),
        .LANE_SKEW(LANE_SKEW), .LEN_LSB(LEN_LSB), .HDR_BYTES(HDR_BYTES)
    ) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
        .i_data(i_data), .i_bypass(i_bypass),
        .o_eng_new(o_eng_new), .o_eng_last(o_eng_last), .o_eng_pt(o_eng_pt),
        .o_pt_size(o_pt_size),
        .i_eng_ready(i_eng_ready), .i_eng_ct(i_eng_ct),
        .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop), .o_phase(o_phase),
        .o_cipher(o_cipher), .o_bypass(o_bypass),
`ifdef GCM_LANE_STATS_EN
        .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt),
`endif
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Engine model: ciphertext = plaintext ^ all-ones, ENG_LAT cycles after o_eng_new.
    logic         sr_v  [LANES][ENG_LAT];
    logic [127:0] sr_ct [LANES][ENG_LAT];
    logic         sup1;

    always @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            for (int k = ENG_LAT - 1; k > 0; k--) begin
                sr_v[l][k]  <= reset ? 1'b0 : sr_v[l][k-1];
                sr_ct[l][k] <= sr_ct[l][k-1];
            end
            sr_v[l][0]  <= reset ? 1'b0 : o_eng_new[l];
            sr_ct[l][0] <= o_eng_pt[128*l +: 128] ^ {128{1'b1}};
        end
    end

    assign i_eng_ready[0] = sr_v[0][ENG_LAT-1];
    assign i_eng_ready[1] = sr_v[1][ENG_LAT-1] & ~sup1;
    assign i_eng_ct       = {sr_ct[1][ENG_LAT-1], sr_ct[0][ENG_LAT-1]};

    typedef struct {
        int                  cyc;
        logic                sop;
        logic                eop;
        logic [2:0]          ph;
        logic [DW-1:0]       ct;
        logic [BYPASS_W-1:0] byp;
    } obeat_t;

    typedef struct {
        logic         v;
        logic         sop;
        logic         eop;
        logic [15:0]  len;
        logic [2:0]   ph;
        logic [127:0] size;
    } vec_t;

    obeat_t        exp_q [$];
    obeat_t        got_q [$];
    int            cyc = 0;
    int            bid = 0;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] cur_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            got_q.push_back('{cyc, o_sop, o_eop, o_phase, o_cipher, o_bypass});
        end
    end

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic v, input logic sop, input logic eop,
                        input logic [15:0] len, input logic acc, input logic [2:0] ph);
        logic [DW-1:0]       d;
        logic [BYPASS_W-1:0] b;
        obeat_t              e;
        bid++;
        d = {{4{32'hC0DE_0000 | bid}}, {4{32'hBEEF_0000 | bid}}};
        b = '0;
        b[31:0] = 32'hB000_0000 | bid;
        b[LEN_LSB +: 16] = len;
        b[BYPASS_W-1 -: 32] = 32'h5A5A_0000 | bid;
        i_valid  = v;
        i_sop    = sop;
        i_eop    = eop;
        i_data   = d;
        i_bypass = b;
        cur_data = d;
        if (v && acc) begin
            e.cyc = cyc + OUT_LAT;
            e.sop = sop;
            e.eop = eop;
            e.ph  = ph;
            e.ct  = d ^ {DW{1'b1}};
            e.byp = b;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    endtask

    task automatic do_reset(input int n);
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        reset   = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_cyc%0d", tag, i), got_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s_sop%0d", tag, i), got_q[i].sop, exp_q[i].sop);
            chk($sformatf("%s_eop%0d", tag, i), got_q[i].eop, exp_q[i].eop);
            chk($sformatf("%s_ph%0d", tag, i), got_q[i].ph, exp_q[i].ph);
            chk($sformatf("%s_ct%0d", tag, i), got_q[i].ct, exp_q[i].ct);
            chk($sformatf("%s_byp%0d", tag, i), got_q[i].byp, exp_q[i].byp);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    vec_t tbl [11];
    logic found;
    logic prev_v;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'h0020, 3'd1, 128'h90};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 128'h90};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0040, 3'd1, 128'h190};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0FFF, 3'd2, 128'h190};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'h0FFF, 3'd4, 128'h190};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h0030, 3'd1, 128'h110};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 3'd2, 128'h110};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 3'd1, 128'h790};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 3'd2, 128'h790};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 128'h790};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h000E, 3'd1, 128'h0};

        sup1     = 1'b0;
        i_data   = '0;
        i_bypass = '0;
        @(negedge clk);
        do_reset(3);

        chk("rst_valid", o_valid, 1'b0);
        chk("rst_err", o_err, 1'b0);
        chk("rst_size", o_pt_size, 128'h0);
        chk("rst_new", o_eng_new, 2'b00);
        chk("rst_cipher", o_cipher, '0);

        prev_v = 1'b0;
        for (int i = 0; i < 11; i++) begin
            beat(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].len, tbl[i].v, tbl[i].ph);
            chk($sformatf("tbl_size%0d", i), o_pt_size, tbl[i].size);
            chk($sformatf("tbl_new%0d", i), o_eng_new, {prev_v, tbl[i].v});
            chk($sformatf("tbl_last%0d", i), o_eng_last[0], tbl[i].v & tbl[i].eop);
            if (tbl[i].v) chk($sformatf("tbl_pt%0d", i), o_eng_pt[127:0], cur_data[127:0]);
            prev_v = tbl[i].v;
        end
        idle(OUT_LAT + 4);
        check_outputs("main");
        chk("main_err", o_err, 1'b0);
        chk("hold_cipher_valid", o_valid, 1'b0);

        beat(1'b1, 1'b1, 1'b0, 16'h0040, 1'b1, 3'd1);
        beat(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd2);
        beat(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd4);
        beat(1'b1, 1'b1, 1'b1, 16'h0020, 1'b1, 3'd1);
        chk("trunc_size", o_pt_size, 128'h90);
        chk("trunc_err", o_err, 1'b1);
        beat(1'b1, 1'b1, 1'b0, 16'h0030, 1'b1, 3'd1);
        beat(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd2);
        idle(OUT_LAT + 4);
        check_outputs("trunc");

        do_reset(2);
        beat(1'b1, 1'b1, 1'b0, 16'h0040, 1'b1, 3'd1);
        beat(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd2);
        idle(3);
        do_reset(2);
        chk("mid_rst_err", o_err, 1'b0);
        chk("mid_rst_size", o_pt_size, 128'h0);
        idle(40);
        chk("mid_rst_noout", got_q.size(), 0);
        chk("mid_rst_err2", o_err, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 3'd0);
        chk("nosop_err", o_err, 1'b1);
        chk("nosop_new", o_eng_new, 2'b00);
        idle(40);
        chk("nosop_noout", got_q.size(), 0);

        do_reset(2);
        beat(1'b1, 1'b1, 1'b0, 16'h0022, 1'b1, 3'd1);
        chk("post_rst_size", o_pt_size, 128'hA0);
        beat(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd2);
        idle(OUT_LAT + 4);
        check_outputs("post_rst");
        chk("post_rst_err", o_err, 1'b0);

        beat(1'b1, 1'b1, 1'b1, 16'h000D, 1'b1, 3'd1);
        chk("short_size", o_pt_size, 128'h0);
        chk("short_err", o_err, 1'b1);
        idle(OUT_LAT + 4);
        check_outputs("short");

        do_reset(2);
        beat(1'b1, 1'b1, 1'b0, 16'h0040, 1'b1, 3'd1);
        beat(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd2);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (sr_v[1][ENG_LAT-1]) found = 1'b1;
            else idle(1);
        end
        chk("sup_found", found, 1'b1);
        sup1 = 1'b1;
        idle(1);
        sup1 = 1'b0;
        chk("sup_err", o_err, 1'b1);
        idle(10);
        check_outputs("sup");
        idle(10);
        chk("sup_err_held", o_err, 1'b1);
`ifdef GCM_LANE_STATS_EN
        chk("stat_err_cnt", o_err_cnt, 16'd1);
        chk("stat_pkt_cnt", o_pkt_cnt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
